rr_rsp_demux: RTL and testbench
===============================

Name: rr_rsp_demux

Overview:
- Return-path companion to the round-robin request arbiter. It records the arbitrated input index of every accepted request in an in-order FIFO.
- It routes each in-order downstream response back to the originating input port.
- It sits between the arbiter's output port (request side) and the N upstream masters (response side). It throttles new requests when MaxTrans responses are outstanding.

Parameters:
- NumOut, 4, number of upstream ports (equals arbiter NumIn); must be >= 1.
- DataWidth, 32, response payload width; unused if DataType overridden.
- DataType, logic [DataWidth-1:0], response payload type.
- MaxTrans, 8, maximum outstanding requests (FIFO depth); must be >= 1.
- IdxWidth, (NumOut > 1) ? clog2(NumOut) : 1, derived, do not override.
- idx_t, logic [IdxWidth-1:0], derived index type.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous reset, active low.
- flush_i  in  1  synchronous clear of all outstanding state.
- req_valid_i  in  1  arbiter output request valid (snooped).
- req_ready_i  in  1  downstream grant for that request (snooped).
- req_idx_i  in  IdxWidth  arbitrated index of the request.
- req_stall_o  out  1  high = no free slot; upstream must gate req_valid/grant.
- rsp_valid_i  in  1  downstream response valid.
- rsp_ready_o  out  1  response accepted.
- rsp_data_i  in  DataType  downstream response payload.
- rsp_valid_o  out  NumOut  per-port response valid, onehot0.
- rsp_ready_i  in  NumOut  per-port response ready.
- rsp_data_o  out  DataType  response payload, broadcast to all ports.
- rsp_idx_o  out  IdxWidth  head index (port currently being served).
- outstanding_o  out  clog2(MaxTrans+1)  current FIFO fill count.

Behaviour:
- Push: on req_valid_i && req_ready_i && !req_stall_o, write req_idx_i to the tail and increment the count.
- A handshake while req_stall_o=1 is a protocol violation. Assert it, and do not push.
- req_stall_o = (count == MaxTrans). It is registered-state only, with no combinational path from pop, so a pop in the same cycle does not unblock the push.
- Routing (head = oldest entry, empty = count==0):
  - rsp_valid_o[k] = rsp_valid_i && !empty && head==k.
  - rsp_ready_o = !empty && rsp_ready_i[head].
  - rsp_data_o = rsp_data_i.
  - rsp_idx_o = head, or 0 when empty.
- No fall-through: an index pushed in cycle t can be used at the earliest in cycle t+1. While empty, rsp_ready_o=0 and all rsp_valid_o=0.
- Pop: on rsp_valid_i && rsp_ready_o, advance the head and decrement the count.
- Push and pop in the same cycle: count unchanged; both pointers advance.
- Pointers wrap from MaxTrans-1 to 0. This must work for non-power-of-2 MaxTrans.
- rsp_valid_o must not depend on rsp_ready_i. rsp_ready_o depends combinationally on rsp_ready_i[head] only.
- NumOut==1: index always 0; behaviour otherwise unchanged.
- flush_i: next cycle count=0, pointers=0. Any push or pop in the flush cycle is discarded.
- Reset values:
  - count=0, pointers=0, FIFO storage don't-care.
  - req_stall_o=0, rsp_ready_o=0, rsp_valid_o=0, rsp_idx_o=0, outstanding_o=0.
  - rsp_data_o follows rsp_data_i.
- Reset mid-operation: all outstanding entries are lost. There is no drain.
- Assertions (sim only, disabled during reset/flush):
  - onehot0(rsp_valid_o).
  - count never exceeds MaxTrans.
  - rsp_valid_i while empty is flagged as an error (response without request).

Test Plan:
- Reset, then idle: all outputs 0, outstanding_o=0; rsp_valid_i=1 with no request -> rsp_ready_o=0, no rsp_valid_o bit set.
- NumOut=4, MaxTrans=8:
  - Push idx 2,0,3 on consecutive cycles, then 3 responses with all ready -> rsp_valid_o sequence 0100, 0001, 1000; rsp_data_o matches rsp_data_i; outstanding_o goes 3 -> 0.
  - Push 8 requests -> req_stall_o=1, outstanding_o=8. The same cycle as the first pop still has stall=1; the next cycle has stall=0 and count=7.
  - Head idx 1, rsp_ready_i=1101 -> rsp_ready_o=0, rsp_valid_o=0010, entry not popped. Raise rsp_ready_i[1] -> pop occurs.
  - Simultaneous push (idx 3) and pop at count=4 -> count stays 4; after draining, the order is preserved through pointer wrap. Repeat with MaxTrans=5 (non-power-of-2).
- flush_i asserted with 5 outstanding plus a concurrent push -> next cycle outstanding_o=0, rsp_ready_o=0; subsequent push/response pairs route correctly.

Source files
------------

// File: rtl/rr_rsp_demux.sv
// -----------------------------------------------------------------------------
// rr_rsp_demux
//
// Return-path companion to the round-robin request arbiter. Every request the
// arbiter hands downstream has its input index recorded in an in-order FIFO.
// Downstream responses are assumed to come back in order. Each one is steered
// to the port at the FIFO head. New requests are throttled once MaxTrans
// responses are outstanding.
//
// Ports
//   clk_i, rst_ni   clock (rising edge), asynchronous active-low reset
//   flush_i         synchronous clear of every outstanding entry
//   req_valid_i     snooped arbiter output request valid
//   req_ready_i     snooped downstream grant for that request
//   req_idx_i       arbitrated input index of the request
//   req_stall_o     no free slot; upstream must gate its valid/grant
//   rsp_valid_i     downstream response valid
//   rsp_ready_o     downstream response accepted by the head port
//   rsp_data_i      downstream response payload
//   rsp_valid_o     per-port response valid (onehot0)
//   rsp_ready_i     per-port response ready
//   rsp_data_o      response payload, broadcast to all ports
//   rsp_idx_o       head index (port currently served), 0 when empty
//   outstanding_o   current FIFO fill count
// -----------------------------------------------------------------------------
module rr_rsp_demux #(
    parameter int unsigned  NumOut    = 4,
    parameter int unsigned  DataWidth = 32,
    parameter type          DataType  = logic [DataWidth-1:0],
    parameter int unsigned  MaxTrans  = 8,
    localparam int unsigned IdxWidth  = (NumOut > 1) ? $clog2(NumOut) : 1,
    localparam type         idx_t     = logic [IdxWidth-1:0],
    localparam int unsigned CntWidth  = $clog2(MaxTrans + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic                req_valid_i,
    input  logic                req_ready_i,
    input  idx_t                req_idx_i,
    output logic                req_stall_o,
    input  logic                rsp_valid_i,
    output logic                rsp_ready_o,
    input  DataType             rsp_data_i,
    output logic [NumOut-1:0]   rsp_valid_o,
    input  logic [NumOut-1:0]   rsp_ready_i,
    output DataType             rsp_data_o,
    output idx_t                rsp_idx_o,
    output logic [CntWidth-1:0] outstanding_o
);

    localparam int unsigned PtrWidth = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
    typedef logic [PtrWidth-1:0] ptr_t;
    localparam ptr_t                LastPtr = ptr_t'(MaxTrans - 1);
    localparam logic [CntWidth-1:0] FullCnt = CntWidth'(MaxTrans);

    idx_t                mem_q [MaxTrans];
    ptr_t                wr_ptr_q, wr_ptr_d;
    ptr_t                rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;

    logic empty;
    logic push;
    logic pop;
    logic head_ready;
    idx_t head_idx;

    // Explicit wrap so non-power-of-2 depths never index past the storage.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == LastPtr) ? '0 : p + ptr_t'(1);
    endfunction

    // Stall comes from registered state only, so a pop in the same cycle does
    // not open a slot for a push until the following cycle.
    assign empty       = (cnt_q == '0);
    assign req_stall_o = (cnt_q == FullCnt);

    assign push = req_valid_i && req_ready_i && !req_stall_o;
    assign pop  = rsp_valid_i && rsp_ready_o;

    if (NumOut == 1) begin : g_single
        assign head_idx = '0;
    end else begin : g_multi
        assign head_idx = mem_q[rd_ptr_q];
    end

    // Valid fan-out never looks at rsp_ready_i; only the accept back to the
    // downstream side depends on the head port's ready.
    always_comb begin
        rsp_valid_o = '0;
        head_ready  = 1'b0;
        for (int unsigned k = 0; k < NumOut; k++) begin
            if (head_idx == idx_t'(k)) begin
                rsp_valid_o[k] = rsp_valid_i && !empty;
                head_ready     = rsp_ready_i[k];
            end
        end
    end

    assign rsp_ready_o   = !empty && head_ready;
    assign rsp_data_o    = rsp_data_i;
    assign rsp_idx_o     = empty ? '0 : head_idx;
    assign outstanding_o = cnt_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                cnt_d = cnt_q + CntWidth'(1);
            end else if (pop && !push) begin
                cnt_d = cnt_q - CntWidth'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Index storage carries no reset; entries are only read once counted.
    always_ff @(posedge clk_i) begin
        if (push && !flush_i) begin
            mem_q[wr_ptr_q] <= req_idx_i;
        end
    end

    a_valid_onehot0 : assert property (
        @(posedge clk_i) disable iff (!rst_ni || flush_i)
        $onehot0(rsp_valid_o))
        else $error("rr_rsp_demux: rsp_valid_o not onehot0");

    a_count_bound : assert property (
        @(posedge clk_i) disable iff (!rst_ni || flush_i)
        cnt_q <= FullCnt)
        else $error("rr_rsp_demux: outstanding count above MaxTrans");

    a_push_when_stalled : assert property (
        @(posedge clk_i) disable iff (!rst_ni || flush_i)
        !(req_valid_i && req_ready_i && req_stall_o))
        else $error("rr_rsp_demux: request handshake while stalled");

    a_rsp_without_req : assert property (
        @(posedge clk_i) disable iff (!rst_ni || flush_i)
        rsp_valid_i |-> !empty)
        else $error("rr_rsp_demux: response with no outstanding request");

endmodule

// File: tb/tb_rr_rsp_demux.sv
// -----------------------------------------------------------------------------
// tb_rr_rsp_demux
//
// Two instances share one stimulus set: sel=0 drives a NumOut=4/MaxTrans=8
// instance, sel=1 a NumOut=4/MaxTrans=5 instance. Handshake inputs are gated
// by sel so the idle instance stays quiet. Outputs are muxed by sel for
// comparison against the expected values in each vector.
// -----------------------------------------------------------------------------
module tb_rr_rsp_demux;

    typedef struct packed {
        logic        sel;
        logic        flush;
        logic        rv;
        logic        rr;
        logic [1:0]  idx;
        logic        sv;
        logic [3:0]  srdy;
        logic [31:0] data;
        logic [3:0]  e_vo;
        logic        e_ro;
        logic [1:0]  e_idx;
        logic        e_stall;
        logic [3:0]  e_out;
    } vec_t;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        sel = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready = 1'b0;
    logic [1:0]  req_idx = '0;
    logic        rsp_valid = 1'b0;
    logic [3:0]  rsp_ready = '0;
    logic [31:0] rsp_data = '0;

    logic        stall_a, stall_b, ro_a, ro_b;
    logic [3:0]  vo_a, vo_b;
    logic [31:0] data_a, data_b;
    logic [1:0]  idx_a, idx_b;
    logic [3:0]  out_a;
    logic [2:0]  out_b;

    logic        stall, ro;
    logic [3:0]  vo, out;
    logic [31:0] dout;
    logic [1:0]  ridx;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk_i = ~clk_i;

    rr_rsp_demux #(.NumOut(4), .MaxTrans(8)) dut_a (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush & ~sel),
        .req_valid_i  (req_valid & ~sel),
        .req_ready_i  (req_ready),
        .req_idx_i    (req_idx),
        .req_stall_o  (stall_a),
        .rsp_valid_i  (rsp_valid & ~sel),
        .rsp_ready_o  (ro_a),
        .rsp_data_i   (rsp_data),
        .rsp_valid_o  (vo_a),
        .rsp_ready_i  (rsp_ready),
        .rsp_data_o   (data_a),
        .rsp_idx_o    (idx_a),
        .outstanding_o(out_a)
    );

    rr_rsp_demux #(.NumOut(4), .MaxTrans(5)) dut_b (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush & sel),
        .req_valid_i  (req_valid & sel),
        .req_ready_i  (req_ready),
        .req_idx_i    (req_idx),
        .req_stall_o  (stall_b),
        .rsp_valid_i  (rsp_valid & sel),
        .rsp_ready_o  (ro_b),
        .rsp_data_i   (rsp_data),
        .rsp_valid_o  (vo_b),
        .rsp_ready_i  (rsp_ready),
        .rsp_data_o   (data_b),
        .rsp_idx_o    (idx_b),
        .outstanding_o(out_b)
    );

    assign stall = sel ? stall_b : stall_a;
    assign ro    = sel ? ro_b : ro_a;
    assign vo    = sel ? vo_b : vo_a;
    assign dout  = sel ? data_b : data_a;
    assign ridx  = sel ? idx_b : idx_a;
    assign out   = sel ? {1'b0, out_b} : out_a;

    task automatic check(input string tag, input string what,
                         input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s %s: got %0h, expected %0h", tag, what, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic s, input logic rv, input logic [1:0] idx,
                                input logic sv, input logic [3:0] srdy,
                                input logic [3:0] e_vo, input logic e_ro,
                                input logic [1:0] e_idx, input logic e_stall,
                                input logic [3:0] e_out);
        vec_t v;
        v.sel     = s;
        v.flush   = 1'b0;
        v.rv      = rv;
        v.rr      = rv;
        v.idx     = idx;
        v.sv      = sv;
        v.srdy    = srdy;
        v.data    = $urandom;
        v.e_vo    = e_vo;
        v.e_ro    = e_ro;
        v.e_idx   = e_idx;
        v.e_stall = e_stall;
        v.e_out   = e_out;
        return v;
    endfunction

    // Inputs land 1 ns after the rising edge; outputs are compared 1 ns later,
    // before the next edge commits the cycle.
    task automatic apply(input vec_t v, input string tag);
        sel       = v.sel;
        flush     = v.flush;
        req_valid = v.rv;
        req_ready = v.rr;
        req_idx   = v.idx;
        rsp_valid = v.sv;
        rsp_ready = v.srdy;
        rsp_data  = v.data;
        #1;
        check(tag, "rsp_valid_o",   32'(vo),    32'(v.e_vo));
        check(tag, "rsp_ready_o",   32'(ro),    32'(v.e_ro));
        check(tag, "rsp_idx_o",     32'(ridx),  32'(v.e_idx));
        check(tag, "req_stall_o",   32'(stall), 32'(v.e_stall));
        check(tag, "outstanding_o", 32'(out),   32'(v.e_out));
        check(tag, "rsp_data_o",    dout,       v.data);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vq[$];
        vec_t v;

        // Response with no request, held during reset: nothing may be routed.
        rsp_valid = 1'b1;
        rsp_ready = 4'b1111;
        repeat (3) @(posedge clk_i);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check("reset", "rsp_valid_o",   32'(vo),    32'h0);
            check("reset", "rsp_ready_o",   32'(ro),    32'h0);
            check("reset", "rsp_idx_o",     32'(ridx),  32'h0);
            check("reset", "req_stall_o",   32'(stall), 32'h0);
            check("reset", "outstanding_o", 32'(out),   32'h0);
        end
        sel       = 1'b0;
        rsp_valid = 1'b0;
        rsp_ready = 4'b0000;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // In-order routing: push 2,0,3 then three responses.
        vq.push_back(mk(0, 1, 2, 0, 4'b1111, 4'b0000, 0, 0, 0, 0));
        vq.push_back(mk(0, 1, 0, 0, 4'b1111, 4'b0000, 1, 2, 0, 1));
        vq.push_back(mk(0, 1, 3, 0, 4'b1111, 4'b0000, 1, 2, 0, 2));
        vq.push_back(mk(0, 0, 0, 1, 4'b1111, 4'b0100, 1, 2, 0, 3));
        vq.push_back(mk(0, 0, 0, 1, 4'b1111, 4'b0001, 1, 0, 0, 2));
        vq.push_back(mk(0, 0, 0, 1, 4'b1111, 4'b1000, 1, 3, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 4'b1111, 4'b0000, 0, 0, 0, 0));
        // Fill to MaxTrans=8 with idx 0,1,2,3,0,1,2,3.
        for (int i = 0; i < 8; i++) begin
            vq.push_back(mk(0, 1, 2'(i % 4), 0, 4'b0000, 4'b0000, 0, 0, 0, 4'(i)));
        end
        // First pop while full still shows stall; next cycle count 7, no stall.
        vq.push_back(mk(0, 0, 0, 1, 4'b1111, 4'b0001, 1, 0, 1, 8));
        vq.push_back(mk(0, 0, 0, 0, 4'b0000, 4'b0000, 0, 1, 0, 7));
        // Head idx 1 with its ready low: valid shown, nothing accepted.
        vq.push_back(mk(0, 0, 0, 1, 4'b1101, 4'b0010, 0, 1, 0, 7));
        vq.push_back(mk(0, 0, 0, 1, 4'b0010, 4'b0010, 1, 1, 0, 7));
        vq.push_back(mk(0, 0, 0, 1, 4'b1111, 4'b0100, 1, 2, 0, 6));
        vq.push_back(mk(0, 0, 0, 1, 4'b1111, 4'b1000, 1, 3, 0, 5));
        // Push idx 3 with a pop at count 4, then drain across the pointer wrap.
        vq.push_back(mk(0, 1, 3, 1, 4'b1111, 4'b0001, 1, 0, 0, 4));
        vq.push_back(mk(0, 0, 0, 1, 4'b1111, 4'b0010, 1, 1, 0, 4));
        vq.push_back(mk(0, 0, 0, 1, 4'b1111, 4'b0100, 1, 2, 0, 3));
        vq.push_back(mk(0, 0, 0, 1, 4'b1111, 4'b1000, 1, 3, 0, 2));
        vq.push_back(mk(0, 0, 0, 1, 4'b1111, 4'b1000, 1, 3, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 4'b1111, 4'b0000, 0, 0, 0, 0));
        // MaxTrans=5: push 1,2,0,3, then push+pop three times across the wrap.
        vq.push_back(mk(1, 1, 1, 0, 4'b1111, 4'b0000, 0, 0, 0, 0));
        vq.push_back(mk(1, 1, 2, 0, 4'b1111, 4'b0000, 1, 1, 0, 1));
        vq.push_back(mk(1, 1, 0, 0, 4'b1111, 4'b0000, 1, 1, 0, 2));
        vq.push_back(mk(1, 1, 3, 0, 4'b1111, 4'b0000, 1, 1, 0, 3));
        vq.push_back(mk(1, 1, 3, 1, 4'b1111, 4'b0010, 1, 1, 0, 4));
        vq.push_back(mk(1, 1, 2, 1, 4'b1111, 4'b0100, 1, 2, 0, 4));
        vq.push_back(mk(1, 1, 1, 1, 4'b1111, 4'b0001, 1, 0, 0, 4));
        vq.push_back(mk(1, 0, 0, 1, 4'b1111, 4'b1000, 1, 3, 0, 4));
        vq.push_back(mk(1, 0, 0, 1, 4'b1111, 4'b1000, 1, 3, 0, 3));
        vq.push_back(mk(1, 0, 0, 1, 4'b1111, 4'b0100, 1, 2, 0, 2));
        vq.push_back(mk(1, 0, 0, 1, 4'b1111, 4'b0010, 1, 1, 0, 1));
        vq.push_back(mk(1, 0, 0, 0, 4'b1111, 4'b0000, 0, 0, 0, 0));
        for (int i = 0; i < 5; i++) begin
            vq.push_back(mk(1, 1, 2'(i % 4), 0, 4'b0000, 4'b0000, 0, 0, 0, 4'(i)));
        end
        vq.push_back(mk(1, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 1, 5));

        for (int i = 0; i < vq.size(); i++) begin
            apply(vq[i], $sformatf("vec%0d", i));
        end

        // Flush with 5 outstanding plus a concurrent push and pop.
        for (int i = 0; i < 5; i++) begin
            v = mk(0, 1, 2'((i + 1) % 4), 0, 4'b0000, 4'b0000, 0, (i == 0) ? 2'd0 : 2'd1, 0, 4'(i));
            apply(v, $sformatf("flush_fill%0d", i));
        end
        v = mk(0, 1, 2, 1, 4'b1111, 4'b0010, 1, 1, 0, 5);
        v.flush = 1'b1;
        apply(v, "flush_cycle");
        // Still flushing, now empty: a stray response must not be accepted.
        v = mk(0, 0, 0, 1, 4'b1111, 4'b0000, 0, 0, 0, 0);
        v.flush = 1'b1;
        apply(v, "flush_empty");
        apply(mk(0, 1, 3, 0, 4'b1111, 4'b0000, 0, 0, 0, 0), "post_push3");
        apply(mk(0, 0, 0, 1, 4'b1111, 4'b1000, 1, 3, 0, 1), "post_rsp3");
        apply(mk(0, 1, 1, 0, 4'b1111, 4'b0000, 0, 0, 0, 0), "post_push1");
        apply(mk(0, 0, 0, 1, 4'b0010, 4'b0010, 1, 1, 0, 1), "post_rsp1");
        apply(mk(0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0), "post_idle");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
